// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word and RAM handshake types, arbiter states
// and owner codes used by the cache/RAM arbiter and its bench.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // RAM handshake state as reported by the memory controller.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter FSM: one arbitration cycle in IDLE, then one word transfer.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    // Debug/perf encoding of who currently holds the RAM port.
    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_I    = 2'd1;
    localparam logic [1:0] OWNER_D    = 2'd2;

    // A dcache request is either a read or a write strobe.
    function automatic logic dcache_req(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM handshake signals around the arbiter.
// The slave view is the arbiter itself; the master view is everything around
// it (both caches and the RAM model).
interface cache_mem_arbiter_if;
    import cpu_types_pkg::*;

    // icache side
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    // dcache side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr,
        output iwait, iload,
        input  dREN, dWEN, daddr, dstore,
        output dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport master (
        output iREN, iaddr,
        input  iwait, iload,
        output dREN, dWEN, daddr, dstore,
        input  dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );

endinterface

// File: rtl/arb_starve_tracker.sv
// Counts how many times in a row the dcache has been granted while the icache
// was also waiting. Saturates at LIMIT; at_limit tells the arbiter that the
// icache must win the next contested arbitration.
module arb_starve_tracker #(
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int              CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_r;

    // Saturating pass-over counter; clear has priority over increment.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != LIMIT_V)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_limit = (cnt_r == LIMIT_V);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single RAM port between the icache (read-only) and the dcache
// (read/write). Dcache has priority, bounded by a starvation guard so the
// icache cannot wait forever. One word transfer per grant, with one IDLE
// arbitration cycle between grants. RAM ERROR cycles are retried and counted.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    cache_mem_arbiter_if.slave   bus,
    output logic [1:0]           owner,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    arb_state_t state_r;
    arb_state_t next_state_s;

    logic  dreq_s;
    logic  starve_inc_s;
    logic  starve_clr_s;
    logic  starve_hit_s;
    logic  granted_err_s;

    logic  ram_ren_s;
    logic  ram_wen_s;
    word_t ram_addr_s;
    word_t ram_store_s;
    logic  iwait_s;
    logic  dwait_s;
    logic  [1:0] owner_s;

    assign dreq_s = dcache_req(bus.dREN, bus.dWEN);

    arb_starve_tracker #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .CLK      (CLK),
        .nRST     (nRST),
        .inc      (starve_inc_s),
        .clr      (starve_clr_s),
        .at_limit (starve_hit_s)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state, RAM drive and cache handshakes. While reset is held every
    // strobe is dropped and both waits stay high, so an interrupted transfer
    // never produces a completion pulse.
    always_comb begin
        next_state_s = state_r;
        ram_ren_s    = 1'b0;
        ram_wen_s    = 1'b0;
        ram_addr_s   = '0;
        ram_store_s  = '0;
        iwait_s      = 1'b1;
        dwait_s      = 1'b1;
        owner_s      = OWNER_NONE;
        starve_inc_s = 1'b0;
        starve_clr_s = 1'b0;

        if (!nRST) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    // Arbitrate; ACCESS seen here belongs to nobody and is ignored.
                    if (dreq_s && bus.iREN && starve_hit_s) begin
                        next_state_s = SERVE_I;
                        starve_clr_s = 1'b1;
                    end else if (dreq_s) begin
                        next_state_s = SERVE_D;
                        starve_inc_s = bus.iREN;
                    end else if (bus.iREN) begin
                        next_state_s = SERVE_I;
                        starve_clr_s = 1'b1;
                    end else begin
                        next_state_s = IDLE;
                    end
                end

                SERVE_I: begin
                    owner_s    = OWNER_I;
                    ram_ren_s  = bus.iREN;
                    ram_addr_s = bus.iaddr;
                    if (!bus.iREN) begin
                        // Request withdrawn: release the port without completing.
                        next_state_s = IDLE;
                    end else if (bus.ramstate == ACCESS) begin
                        iwait_s      = 1'b0;
                        next_state_s = IDLE;
                    end else begin
                        // BUSY/FREE/ERROR: hold strobes so RAM keeps (re)trying.
                        next_state_s = SERVE_I;
                    end
                end

                SERVE_D: begin
                    owner_s     = OWNER_D;
                    ram_wen_s   = bus.dWEN;
                    ram_ren_s   = bus.dREN & ~bus.dWEN;
                    ram_addr_s  = bus.daddr;
                    ram_store_s = bus.dstore;
                    if (!dreq_s) begin
                        next_state_s = IDLE;
                    end else if (bus.ramstate == ACCESS) begin
                        dwait_s      = 1'b0;
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = SERVE_D;
                    end
                end

                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    assign bus.ramREN   = ram_ren_s;
    assign bus.ramWEN   = ram_wen_s;
    assign bus.ramaddr  = ram_addr_s;
    assign bus.ramstore = ram_store_s;
    assign bus.iwait    = iwait_s;
    assign bus.dwait    = dwait_s;
    // Load data is only meaningful in the completion cycle, so both caches
    // simply see the RAM read bus.
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
    assign owner        = owner_s;

    assign granted_err_s = (state_r != IDLE) && (bus.ramstate == ERROR);

    // Saturating count of RAM ERROR cycles seen while a cache holds the port.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            err_cnt <= '0;
        end else if (granted_err_s && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end else begin
            err_cnt <= err_cnt;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a reference model of who holds the RAM port.
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT   = 4;
    localparam int ERR_W   = 8;
    localparam int ERR_SAT = 255;

    logic             CLK;
    logic             nRST;
    logic [1:0]       owner;
    logic [ERR_W-1:0] err_cnt;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .ERR_CNT_W    (ERR_W)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .bus     (bus),
        .owner   (owner),
        .err_cnt (err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who holds the port (0 none, 1 icache, 2 dcache), how
    // many times the icache has been passed over, and the error tally.
    int m_holder = 0;
    int m_pass   = 0;
    int m_err    = 0;
    bit m_known  = 1'b0;

    bit         i_done;
    bit         d_done;
    int         i_obs;
    int         d_obs;
    logic [1:0] prev_owner = 2'd0;
    logic [1:0] grant_log[$];
    logic [1:0] exp_grants4 [6];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs already driven at the falling edge; check the
    // combinational outputs mid-cycle, advance the model at the rising edge.
    task automatic run_cycle();
        bit dr;
        bit acc;
        bit e_iw;
        bit e_dw;
        bit e_rr;
        bit e_rw;
        int nh;
        int np;
        int ne;
        #1;
        dr  = bus.dREN | bus.dWEN;
        acc = (bus.ramstate == ACCESS);
        e_iw = !(nRST && m_holder == 1 && bus.iREN && acc);
        e_dw = !(nRST && m_holder == 2 && dr && acc);
        e_rr = nRST && ((m_holder == 1 && bus.iREN) || (m_holder == 2 && bus.dREN && !bus.dWEN));
        e_rw = nRST && m_holder == 2 && bus.dWEN;

        check_val("owner", owner, nRST ? m_holder : 0);
        check_val("iwait", bus.iwait, e_iw);
        check_val("dwait", bus.dwait, e_dw);
        check_val("ramREN", bus.ramREN, e_rr);
        check_val("ramWEN", bus.ramWEN, e_rw);
        if (nRST && m_holder == 1) check_val("ramaddr_i", bus.ramaddr, bus.iaddr);
        if (nRST && m_holder == 2) begin
            check_val("ramaddr_d", bus.ramaddr, bus.daddr);
            check_val("ramstore", bus.ramstore, bus.dstore);
        end
        if (!e_iw) check_val("iload", bus.iload, bus.ramload);
        if (!e_dw && !bus.dWEN) check_val("dload", bus.dload, bus.ramload);
        if (m_known) begin
            check_val("err_cnt", err_cnt, m_err);
            check_val("starve_cnt", dut.u_starve.cnt_r, m_pass);
        end

        if (owner != 2'd0 && prev_owner == 2'd0) grant_log.push_back(owner);
        prev_owner = owner;
        if (bus.iwait === 1'b0) i_obs++;
        if (bus.dwait === 1'b0) d_obs++;
        i_done = !e_iw;
        d_done = !e_dw;

        nh = m_holder;
        np = m_pass;
        ne = m_err;
        if (!nRST) begin
            nh = 0;
            np = 0;
            ne = 0;
        end else begin
            if (m_holder != 0 && bus.ramstate == ERROR && m_err < ERR_SAT) ne = m_err + 1;
            if (m_holder == 0) begin
                // Icache goes first once it has been passed over LIMIT times.
                if (bus.iREN && (!dr || m_pass >= LIMIT)) begin
                    nh = 1;
                    np = 0;
                end else if (dr) begin
                    nh = 2;
                    if (bus.iREN) np = (m_pass + 1 > LIMIT) ? LIMIT : m_pass + 1;
                end
            end else if (m_holder == 1) begin
                if (!bus.iREN || acc) nh = 0;
            end else begin
                if (!dr || acc) nh = 0;
            end
        end

        @(posedge CLK);
        m_holder = nh;
        m_pass   = np;
        m_err    = ne;
        if (!nRST) m_known = 1'b1;
        @(negedge CLK);
    endtask

    task automatic drive(input bit rst_n, input bit iren, input word_t ia,
                         input bit dren, input bit dwen, input word_t da, input word_t ds,
                         input ramstate_t rs, input word_t rl);
        nRST         = rst_n;
        bus.iREN     = iren;
        bus.iaddr    = ia;
        bus.dREN     = dren;
        bus.dWEN     = dwen;
        bus.daddr    = da;
        bus.dstore   = ds;
        bus.ramstate = rs;
        bus.ramload  = rl;
        run_cycle();
    endtask

    initial begin
        bit    i_pend;
        bit    d_pend;
        int    k;
        word_t a0;

        exp_grants4 = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
        i_pend = 1'b0;
        d_pend = 1'b0;

        // 1: reset held with icache requesting
        drive(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h0);
        drive(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h0);
        check_val("t1_err_cnt", err_cnt, 0);

        // 2: icache only, two BUSY cycles then ACCESS, then the bubble
        i_obs = 0;
        drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE,   32'h0);
        drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY,   32'h0);
        drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY,   32'h0);
        drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'hDEADBEEF);
        drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h0);
        check_val("t2_bubble_owner", owner, 2'd1);
        check_val("t2_ipulses", i_obs, 1);
        drive(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        drive(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h55);
        drive(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h66);

        // 3: simultaneous dcache write and icache read
        grant_log.delete();
        drive(1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h12345678, FREE,   32'h0);
        drive(1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h12345678, ACCESS, 32'h0);
        drive(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  32'h0,        FREE,   32'h0);
        drive(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  32'h0,        ACCESS, 32'hCAFEF00D);
        drive(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        FREE,   32'h0);
        check_val("t3_ngrants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check_val("t3_first", grant_log[0], 2'd2);
            check_val("t3_second", grant_log[1], 2'd1);
        end

        // 4: starvation guard, dcache reads back to back with icache waiting
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        grant_log.delete();
        prev_owner = 2'd0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200 + 32'(c), 32'h0, ACCESS, 32'h1000 + 32'(c));
        end
        check_val("t4_ngrants", grant_log.size(), 6);
        if (grant_log.size() == 6) begin
            for (int g = 0; g < 6; g++) check_val("t4_grant", grant_log[g], exp_grants4[g]);
        end

        // 5: ERROR retries during a dcache read
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        d_obs = 0;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, FREE,  32'h0);
        for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, ERROR, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, ACCESS, 32'h77);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   32'h0, ERROR,  32'h0);
        check_val("t5_err_cnt", err_cnt, 3);
        check_val("t5_dpulses", d_obs, 1);

        // 6: reset in the middle of an icache transfer, then re-request
        i_obs = 0;
        drive(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, FREE,   32'h0);
        drive(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, BUSY,   32'h0);
        drive(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, BUSY,   32'h0);
        drive(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h0);
        check_val("t6_no_pulse", i_obs, 0);
        drive(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h0);
        check_val("t6_idle_after_rst", owner, 2'd1);
        drive(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h99);
        check_val("t6_ipulses", i_obs, 1);

        // Random traffic: caches hold a request until it completes (or
        // occasionally withdraw it), RAM answers with mixed states.
        for (int c = 0; c < 3000; c++) begin
            nRST = ($urandom_range(0, 149) != 0);
            if (!i_pend && $urandom_range(0, 3) == 0) begin
                i_pend    = 1'b1;
                bus.iaddr = $urandom;
            end else if (i_pend && $urandom_range(0, 29) == 0) begin
                i_pend = 1'b0;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend     = 1'b1;
                k          = $urandom_range(0, 2);
                bus.dREN   = (k != 1);
                bus.dWEN   = (k != 0);
                bus.daddr  = $urandom;
                bus.dstore = $urandom;
            end else if (d_pend && $urandom_range(0, 29) == 0) begin
                d_pend = 1'b0;
            end
            if (d_pend && $urandom_range(0, 7) == 0) begin
                a0         = $urandom;
                bus.daddr  = a0;
                bus.dstore = ~a0;
            end
            if (i_pend && $urandom_range(0, 9) == 0) bus.iaddr = $urandom;
            bus.iREN = i_pend;
            if (!d_pend) begin
                bus.dREN = 1'b0;
                bus.dWEN = 1'b0;
            end
            k = $urandom_range(0, 9);
            bus.ramstate = (k < 4) ? ACCESS : (k < 7) ? BUSY : (k < 8) ? ERROR : FREE;
            bus.ramload  = $urandom;
            run_cycle();
            if (i_done) i_pend = 1'b0;
            if (d_done) d_pend = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
